// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem: memory responder for the 6502 CPU bus.
// Serves a mirrored work RAM and a mirrored program ROM to the CPU, with
// optional read wait-states signalled on rdy. Unmapped reads leave Rdata
// untouched, which models open bus. A byte-stream loader can refill the ROM
// while the CPU is held off with rdy low.
module cpu_bus_mem #(
  parameter int          RAM_AW   = 11,
  parameter logic [15:0] RAM_END  = 16'h1FFF,
  parameter int          ROM_AW   = 15,
  parameter logic [15:0] ROM_BASE = 16'h8000,
  parameter int          RD_LAT   = 1
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] Addr_bus,
  input  logic        R_nW,
  input  logic [7:0]  Wdata,
  output logic [7:0]  Rdata,
  output logic        rdy,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  // A read longer than one clock parks the address and counts down in WAIT.
  localparam bit          MULTI_CYCLE = (RD_LAT > 1);
  localparam logic [2:0]  WAIT_INIT   = 3'(RD_LAT - 1);
  localparam logic [ROM_AW-1:0] PTR_MAX = '1;

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        rom [2**ROM_AW];

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [15:0]       addr_q;
  logic [ROM_AW-1:0] ptr;
  logic              start_pend;

  logic [15:0]       rd_addr;
  logic [7:0]        rd_byte;
  logic              ram_we;
  logic              rom_we;
  logic              load_end;

  assign rdy      = (state == IDLE);
  assign ld_ready = (state == LOAD);

  assign ram_we   = (state == IDLE) && !R_nW && (Addr_bus <= RAM_END);
  assign rom_we   = (state == LOAD) && ld_valid;
  // A load stops on the tagged last byte or once the final ROM slot is filled,
  // so a long stream can never wrap around and overwrite offset 0.
  assign load_end = rom_we && (ld_last || (ptr == PTR_MAX));

  // Decode the read address; an unmapped address returns the current Rdata (open bus).
  always_comb begin
    rd_addr = (state == WAIT) ? addr_q : Addr_bus;
    rd_byte = Rdata;
    if (rd_addr <= RAM_END) begin
      rd_byte = ram[rd_addr[RAM_AW-1:0]];
    end else if (rd_addr >= ROM_BASE) begin
      rd_byte = rom[rd_addr[ROM_AW-1:0]];
    end
  end

  // Work RAM write port, CPU side only; contents survive reset.
  always_ff @(posedge clk_ph1) begin
    if (ram_we) begin
      ram[Addr_bus[RAM_AW-1:0]] <= Wdata;
    end
  end

  // Program ROM write port, fed only by the loader; contents survive reset.
  always_ff @(posedge clk_ph1) begin
    if (rom_we) begin
      rom[ptr] <= ld_data;
    end
  end

  // Access sequencer: single-cycle accesses in IDLE, wait-states in WAIT, ROM fill in LOAD.
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      Rdata      <= 8'h00;
      cnt        <= 3'd0;
      addr_q     <= 16'h0000;
      ptr        <= '0;
      start_pend <= 1'b0;
      ld_done    <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (R_nW && MULTI_CYCLE) begin
            addr_q     <= Addr_bus;
            cnt        <= WAIT_INIT;
            start_pend <= ld_start;
            state      <= WAIT;
          end else begin
            if (R_nW) begin
              Rdata <= rd_byte;
            end
            if (ld_start) begin
              ptr   <= '0;
              state <= LOAD;
            end
          end
        end
        WAIT: begin
          if (ld_start) begin
            start_pend <= 1'b1;
          end
          if (cnt == 3'd1) begin
            Rdata      <= rd_byte;
            start_pend <= 1'b0;
            if (start_pend || ld_start) begin
              ptr   <= '0;
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        LOAD: begin
          if (rom_we) begin
            if (load_end) begin
              ptr     <= '0;
              ld_done <= 1'b1;
              state   <= IDLE;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_mem.sv
// tb_cpu_bus_mem: randomized bench for cpu_bus_mem against a plain array model.
// The model tracks RAM/ROM contents and the last value read by the CPU, and
// derives every expected value from the address map and latency rules.
module tb_cpu_bus_mem;

  localparam int RD_LAT   = 3;
  localparam int RAM_SIZE = 2048;
  localparam int ROM_SIZE = 16384;

  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h4000;
  logic        r_nw = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        rdy;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_done;

  logic [7:0]  ram_m [RAM_SIZE];
  logic [7:0]  rom_m [ROM_SIZE];
  logic [7:0]  exp_rdata = 8'h00;
  logic [7:0]  load_q [$];

  int checks = 0;
  int errors = 0;

  cpu_bus_mem #(
    .RAM_AW  (11),
    .RAM_END (16'h1FFF),
    .ROM_AW  (14),
    .ROM_BASE(16'h8000),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .Addr_bus(addr),
    .R_nW    (r_nw),
    .Wdata   (wdata),
    .Rdata   (rdata),
    .rdy     (rdy),
    .ld_start(ld_start),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .ld_ready(ld_ready),
    .ld_done (ld_done)
  );

  always #5 clk_ph1 = ~clk_ph1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // The CPU view of memory: a RAM byte, a ROM byte, or whatever was last read.
  function automatic logic [7:0] modelRead(input logic [15:0] a);
    if (a <= 16'h1FFF) return ram_m[int'(a) % RAM_SIZE];
    if (a >= 16'h8000) return rom_m[(int'(a) - 32768) % ROM_SIZE];
    return exp_rdata;
  endfunction

  // Park the bus on a harmless write to unmapped space between accesses.
  task automatic busIdle();
    addr  = 16'h4000;
    r_nw  = 1'b0;
    wdata = 8'h00;
  endtask

  // One CPU access, held until rdy; checks wait-state count and Rdata.
  task automatic applyStimulus(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    int waits;
    addr  = a;
    r_nw  = rnw;
    wdata = d;
    @(posedge clk_ph1); #1;
    waits = 0;
    while (!rdy && waits < 20) begin
      waits++;
      @(posedge clk_ph1); #1;
    end
    if (rnw) begin
      exp_rdata = modelRead(a);
      checkOutput("read_waits", waits, RD_LAT - 1);
      checkOutput("read_data", rdata, exp_rdata);
    end else begin
      if (a <= 16'h1FFF) ram_m[int'(a) % RAM_SIZE] = d;
      checkOutput("write_waits", waits, 0);
      checkOutput("write_keeps_rdata", rdata, exp_rdata);
    end
    busIdle();
  endtask

  // Pulse ld_start while the bus is idle; the block should be in LOAD next cycle.
  task automatic startLoad();
    ld_start = 1'b1;
    @(posedge clk_ph1); #1;
    ld_start = 1'b0;
    checkOutput("ld_ready_on", ld_ready, 1);
    checkOutput("rdy_low_in_load", rdy, 0);
  endtask

  // Stream load_q from offset 0 with random valid gaps, then check the done pulse.
  task automatic streamLoad(input bit use_last);
    int n;
    n = load_q.size();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        @(posedge clk_ph1); #1;
      end
      ld_valid = 1'b1;
      ld_data  = load_q[i];
      ld_last  = use_last && (i == n - 1);
      @(posedge clk_ph1); #1;
      rom_m[i] = load_q[i];
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checkOutput("ld_done_pulse", ld_done, 1);
    checkOutput("ld_ready_off", ld_ready, 0);
    checkOutput("rdy_after_load", rdy, 1);
    @(posedge clk_ph1); #1;
    checkOutput("ld_done_one_cycle", ld_done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] a;
    int region;

    // Power-on reset and reset-state checks.
    repeat (3) @(posedge clk_ph1);
    #1;
    checkOutput("por_rdata", rdata, 8'h00);
    checkOutput("por_rdy", rdy, 1);
    checkOutput("por_ld_ready", ld_ready, 0);
    checkOutput("por_ld_done", ld_done, 0);
    rst = 1'b1;

    // Fill all of RAM through random mirror aliases.
    for (int i = 0; i < RAM_SIZE; i++) begin
      applyStimulus(16'(i + RAM_SIZE * $urandom_range(0, 3)), 1'b0, 8'($urandom));
    end

    // Fill the whole ROM without ld_last: the load must end on the final slot.
    load_q.delete();
    for (int i = 0; i < ROM_SIZE; i++) load_q.push_back(8'($urandom));
    startLoad();
    streamLoad(1'b0);
    applyStimulus(16'hFFFF, 1'b1, 8'h00);
    applyStimulus(16'h8000, 1'b1, 8'h00);

    // Asynchronous reset in the middle of a wait-stated read.
    applyStimulus(16'h0005, 1'b0, 8'hC3);
    applyStimulus(16'h0005, 1'b1, 8'h00);
    addr = 16'h0005;
    r_nw = 1'b1;
    @(posedge clk_ph1); #3;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_rdata", rdata, 8'h00);
    checkOutput("async_rst_rdy", rdy, 1);
    checkOutput("async_rst_ld_ready", ld_ready, 0);
    checkOutput("async_rst_ld_done", ld_done, 0);
    exp_rdata = 8'h00;
    busIdle();
    @(posedge clk_ph1); #1;
    rst = 1'b1;

    // Short tagged load, then ROM mirror read.
    load_q = '{8'hA2, 8'hFD, 8'h9A, 8'h68};
    startLoad();
    streamLoad(1'b1);
    applyStimulus(16'h8000, 1'b1, 8'h00);
    checkOutput("rom_0000", rdata, 8'hA2);
    applyStimulus(16'hC001, 1'b1, 8'h00);
    checkOutput("rom_mirror_c001", rdata, 8'hFD);

    // RAM mirrors and open bus.
    applyStimulus(16'h0001, 1'b0, 8'h55);
    applyStimulus(16'h0801, 1'b1, 8'h00);
    checkOutput("ram_mirror_0801", rdata, 8'h55);
    applyStimulus(16'h1801, 1'b1, 8'h00);
    checkOutput("ram_mirror_1801", rdata, 8'h55);
    applyStimulus(16'h4000, 1'b1, 8'h00);
    checkOutput("open_bus_4000", rdata, 8'h55);

    // Wait-stated ROM read and dropped ROM write.
    applyStimulus(16'h8002, 1'b1, 8'h00);
    checkOutput("rom_0002", rdata, 8'h9A);
    applyStimulus(16'h8000, 1'b0, 8'h77);
    applyStimulus(16'h8000, 1'b1, 8'h00);
    checkOutput("rom_write_dropped", rdata, 8'hA2);

    // ld_start arriving during WAIT: the read finishes, then LOAD follows directly.
    addr = 16'h8003;
    r_nw = 1'b1;
    @(posedge clk_ph1); #1;
    checkOutput("wait_rdy_low", rdy, 0);
    ld_start = 1'b1;
    @(posedge clk_ph1); #1;
    ld_start = 1'b0;
    checkOutput("wait_not_loading", ld_ready, 0);
    checkOutput("wait_still_busy", rdy, 0);
    @(posedge clk_ph1); #1;
    exp_rdata = modelRead(16'h8003);
    checkOutput("wait_exit_rdata", rdata, 8'h68);
    checkOutput("load_after_wait", ld_ready, 1);
    busIdle();
    load_q = '{8'h5A, 8'hA5};
    streamLoad(1'b1);
    applyStimulus(16'h8001, 1'b1, 8'h00);

    // Reset in the middle of a load keeps the bytes already written.
    startLoad();
    ld_valid = 1'b1;
    ld_data  = 8'h11;
    @(posedge clk_ph1); #1;
    ld_data  = 8'h22;
    @(posedge clk_ph1); #1;
    ld_valid = 1'b0;
    rom_m[0] = 8'h11;
    rom_m[1] = 8'h22;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("load_rst_ld_ready", ld_ready, 0);
    checkOutput("load_rst_rdy", rdy, 1);
    checkOutput("load_rst_rdata", rdata, 8'h00);
    exp_rdata = 8'h00;
    @(posedge clk_ph1); #1;
    rst = 1'b1;
    applyStimulus(16'h8000, 1'b1, 8'h00);
    checkOutput("kept_after_rst", rdata, 8'h11);
    load_q = '{8'h33};
    startLoad();
    streamLoad(1'b1);
    applyStimulus(16'h8000, 1'b1, 8'h00);
    checkOutput("reload_offset0", rdata, 8'h33);
    applyStimulus(16'h8001, 1'b1, 8'h00);
    checkOutput("reload_keeps_1", rdata, 8'h22);

    // Random CPU traffic over all regions.
    for (int i = 0; i < 400; i++) begin
      region = $urandom_range(0, 3);
      if (region == 0)      a = 16'($urandom_range(0, 16'h1FFF));
      else if (region == 1) a = 16'($urandom_range(16'h2000, 16'h7FFF));
      else                  a = 16'($urandom_range(16'h8000, 16'hFFFF));
      applyStimulus(a, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
